ks_string_voice: RTL and testbench

Karplus-Strong plucked-string voice that produces one signed 16-bit sample per sample-period request and hands it to the audio DAC serializer as its parallel sample word. It holds a circular delay line in a single-port synchronous RAM and fills it with LFSR noise on a pluck. Each request returns the delay-line head and writes back a damped two-tap average. It runs in the 18.432 MHz audio clock domain; the sample request is an LRCK-derived single-cycle pulse in that domain.

---
 rtl/ks_pkg.sv | 35 +++
 rtl/ks_string_voice_if.sv | 26 ++
 rtl/ks_delay_ram.sv | 31 +++
 rtl/ks_string_voice.sv | 183 ++++++++++++++++++
 tb/tb_ks_string_voice.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ks_pkg.sv
// Shared types and helpers for the Karplus-Strong string voice.
// Holds FSM encoding, default widths, LFSR seed/taps and the length clamp.
package ks_pkg;

    localparam int          KS_DATA_WIDTH = 16;
    localparam int          KS_ADDR_WIDTH = 9;
    localparam logic [15:0] KS_LFSR_SEED  = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 as register bits 15, 13, 12, 10
    localparam logic [15:0] KS_LFSR_TAPS  = 16'hB400;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_FILL,
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_CALC,
        ST_WR
    } ks_state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & KS_LFSR_TAPS)};
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len < 2) begin
            return 2;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/ks_string_voice_if.sv
// Control and sample-word bundle between the sample-rate sequencer and the string voice.
// master drives requests/pluck/settings; slave returns the sample word, valid and busy.
interface ks_string_voice_if
    import ks_pkg::*;
#(
    parameter int DATA_WIDTH = KS_DATA_WIDTH,
    parameter int ADDR_WIDTH = KS_ADDR_WIDTH
);
    logic                         iSAMPLE_REQ;
    logic                         iPLUCK;
    logic [ADDR_WIDTH:0]          iLEN;
    logic [3:0]                   iDAMP;
    logic signed [DATA_WIDTH-1:0] oSAMPLE;
    logic                         oVALID;
    logic                         oBUSY;

    modport master (
        output iSAMPLE_REQ, iPLUCK, iLEN, iDAMP,
        input  oSAMPLE, oVALID, oBUSY
    );

    modport slave (
        input  iSAMPLE_REQ, iPLUCK, iLEN, iDAMP,
        output oSAMPLE, oVALID, oBUSY
    );
endinterface

// File: rtl/ks_delay_ram.sv
// Single-port delay-line RAM, registered read (1-cycle latency), read-before-write.
// One access per cycle; no backpressure.
module ks_delay_ram
    import ks_pkg::*;
#(
    parameter int DATA_WIDTH = KS_DATA_WIDTH,
    parameter int ADDR_WIDTH = KS_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    output logic [DATA_WIDTH-1:0] rd_dat
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_dat_q;
    logic [DATA_WIDTH-1:0] rd_dat_d;

    always_comb begin
        rd_dat_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_dat;
        end
        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;
endmodule

// File: rtl/ks_string_voice.sv
// Karplus-Strong plucked-string voice: one signed sample per request, 4-cycle request latency.
// Requests during CLEAR/FILL get a muted 0; requests during an active read-modify-write are dropped.
module ks_string_voice
    import ks_pkg::*;
#(
    parameter int          DATA_WIDTH = KS_DATA_WIDTH,
    parameter int          ADDR_WIDTH = KS_ADDR_WIDTH,
    parameter logic [15:0] LFSR_SEED  = KS_LFSR_SEED
) (
    input  logic         iCLK_18_4,
    input  logic         iRST,
    ks_string_voice_if.slave bus
);
    localparam int unsigned MAX_LEN = 2**ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0]        addr_t;
    typedef logic [ADDR_WIDTH:0]          len_t;
    typedef logic signed [DATA_WIDTH-1:0] smp_t;

    ks_state_t   state_q, state_d;
    addr_t       ptr_q, ptr_d;
    addr_t       wr_idx_q, wr_idx_d;
    len_t        len_q, len_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        pluck_pend_q, pluck_pend_d;
    smp_t        a_q, a_d;
    smp_t        b_q, b_d;
    logic [3:0]  damp_q, damp_d;
    smp_t        sample_q, sample_d;
    logic        valid_q, valid_d;

    logic        ram_we;
    addr_t       ram_addr;
    smp_t        ram_wdat;
    smp_t        ram_rdat;

    addr_t                 nxt;
    logic signed [DATA_WIDTH:0] sum;
    smp_t                  avg;
    smp_t                  y;
    smp_t                  fill_dat;
    logic                  busy;

    ks_delay_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (iCLK_18_4),
        .wr_en  (ram_we),
        .addr   (ram_addr),
        .wr_dat (ram_wdat),
        .rd_dat (ram_rdat)
    );

    always_comb begin
        nxt      = (len_t'(ptr_q) == len_q - len_t'(1)) ? '0 : ptr_q + addr_t'(1);
        sum      = {a_q[DATA_WIDTH-1], a_q} + {b_q[DATA_WIDTH-1], b_q};
        avg      = smp_t'(sum >>> 1);
        y        = (damp_q == 4'd0) ? avg : avg - (avg >>> damp_q);
        fill_dat = smp_t'($signed(lfsr_q) >>> 1);
        busy     = (state_q == ST_CLEAR) || (state_q == ST_FILL);
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        wr_idx_d     = wr_idx_q;
        len_d        = len_q;
        lfsr_d       = lfsr_q;
        pluck_pend_d = pluck_pend_q;
        a_d          = a_q;
        b_d          = b_q;
        damp_d       = damp_q;
        sample_d     = sample_q;
        valid_d      = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = ptr_q;
        ram_wdat     = '0;

        if (bus.iPLUCK && state_q != ST_FILL) begin
            pluck_pend_d = 1'b1;
        end

        // The line is unavailable while being rewritten, so requests are answered with silence.
        if (busy && bus.iSAMPLE_REQ && !valid_q) begin
            sample_d = '0;
            valid_d  = 1'b1;
        end

        case (state_q)
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = wr_idx_q;
                ram_wdat = '0;
                wr_idx_d = wr_idx_q + addr_t'(1);
                if (wr_idx_q == addr_t'(MAX_LEN - 1)) begin
                    wr_idx_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_FILL: begin
                ram_we   = 1'b1;
                ram_addr = wr_idx_q;
                ram_wdat = fill_dat;
                lfsr_d   = lfsr_step(lfsr_q);
                wr_idx_d = wr_idx_q + addr_t'(1);
                if (len_t'(wr_idx_q) == len_q - len_t'(1)) begin
                    wr_idx_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.iSAMPLE_REQ) begin
                    state_d = ST_RD_A;
                end else if (pluck_pend_q) begin
                    state_d      = ST_FILL;
                    len_d        = len_t'(clamp_len(32'(bus.iLEN), MAX_LEN));
                    ptr_d        = '0;
                    wr_idx_d     = '0;
                    pluck_pend_d = 1'b0;
                end
            end
            ST_RD_A: begin
                ram_addr = ptr_q;
                state_d  = ST_RD_B;
            end
            ST_RD_B: begin
                ram_addr = nxt;
                a_d      = ram_rdat;
                state_d  = ST_CALC;
            end
            ST_CALC: begin
                b_d     = ram_rdat;
                damp_d  = bus.iDAMP;
                state_d = ST_WR;
            end
            ST_WR: begin
                ram_we   = 1'b1;
                ram_addr = ptr_q;
                ram_wdat = y;
                sample_d = a_q;
                valid_d  = 1'b1;
                ptr_d    = nxt;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            wr_idx_q     <= '0;
            len_q        <= len_t'(2);
            lfsr_q       <= LFSR_SEED;
            pluck_pend_q <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            damp_q       <= '0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            wr_idx_q     <= wr_idx_d;
            len_q        <= len_d;
            lfsr_q       <= lfsr_d;
            pluck_pend_q <= pluck_pend_d;
            a_q          <= a_d;
            b_q          <= b_d;
            damp_q       <= damp_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
        end
    end

    assign bus.oSAMPLE = sample_q;
    assign bus.oVALID  = valid_q;
    assign bus.oBUSY   = busy;
endmodule

// File: tb/tb_ks_string_voice.sv
// Directed bench for ks_string_voice: hand-computed vector table plus corner-case sequences.
module tb_ks_string_voice;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ks_string_voice_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) bus ();

    ks_string_voice dut (
        .iCLK_18_4 (clk),
        .iRST      (rst),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] lfsr_m;
    int          line_m [512];
    int          mlen;
    int          mptr;

    typedef struct {
        int damp;
        int exp;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int avg2(input int a, input int b);
        return (a + b) >>> 1;
    endfunction

    function automatic int damp_f(input int v, input int d);
        return (d == 0) ? v : v - (v >>> d);
    endfunction

    task automatic m_fill(input int n);
        mlen = n;
        mptr = 0;
        for (int i = 0; i < n; i++) begin
            line_m[i] = int'($signed(lfsr_m)) >>> 1;
            lfsr_m    = m_step(lfsr_m);
        end
    endtask

    task automatic m_serve(input int d, output int e);
        int nx;
        nx = (mptr == mlen - 1) ? 0 : mptr + 1;
        e  = line_m[mptr];
        line_m[mptr] = damp_f(avg2(line_m[mptr], line_m[nx]), d);
        mptr = nx;
    endtask

    task automatic serve(input bit with_pluck, output int s, output int lat);
        bus.iSAMPLE_REQ = 1'b1;
        bus.iPLUCK      = with_pluck;
        tick();
        bus.iSAMPLE_REQ = 1'b0;
        bus.iPLUCK      = 1'b0;
        lat = -1;
        s   = -99999;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.oVALID) begin
                lat = i;
                s   = int'(bus.oSAMPLE);
                break;
            end
        end
    endtask

    task automatic pluck(input int len);
        bus.iLEN   = 10'(len);
        bus.iPLUCK = 1'b1;
        tick();
        bus.iPLUCK = 1'b0;
    endtask

    task automatic fill_len(input int pluck_at, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.oBUSY) break;
            tick();
        end
        while (bus.oBUSY && n < 2000) begin
            n++;
            bus.iPLUCK = (n == pluck_at);
            tick();
            bus.iPLUCK = 1'b0;
        end
    endtask

    task automatic run_clear(input int req_at, output int busy_n, output int vld_n,
                             output int vld_at, output int mute_s);
        rst    = 1'b0;
        busy_n = 0;
        vld_n  = 0;
        vld_at = -1;
        mute_s = -1;
        for (int i = 0; i < 2000; i++) begin
            bus.iSAMPLE_REQ = (i == req_at);
            tick();
            bus.iSAMPLE_REQ = 1'b0;
            if (bus.oVALID) begin
                vld_n++;
                vld_at = i;
                mute_s = int'(bus.oSAMPLE);
            end
            if (!bus.oBUSY) begin
                busy_n = i + 1;
                break;
            end
        end
    endtask

    initial begin
        int s, lat, e, n, bad, latbad, busy_n, vld_n, vld_at, mute_s, f0, f1, vc, grow, peak, prev;
        int outs [520];

        bus.iSAMPLE_REQ = 1'b0;
        bus.iPLUCK      = 1'b0;
        bus.iLEN        = '0;
        bus.iDAMP       = '0;
        lfsr_m          = 16'hACE1;

        tbl[0] = '{0, int'($signed(16'hD670))};
        tbl[1] = '{0, int'($signed(16'h2CE1))};
        tbl[2] = '{0, int'($signed(16'hD9C3))};
        tbl[3] = '{0, int'($signed(16'h3387))};
        tbl[4] = '{0, int'($signed(16'h01A8))};
        tbl[5] = '{0, int'($signed(16'h0352))};
        tbl[6] = '{0, int'($signed(16'h06A5))};
        tbl[7] = '{0, int'($signed(16'h1A97))};

        // Reset state and CLEAR duration with a muted request inside it
        repeat (3) tick();
        check("rst_busy", int'(bus.oBUSY), 1);
        check("rst_valid", int'(bus.oVALID), 0);
        check("rst_sample", int'(bus.oSAMPLE), 0);
        run_clear(20, busy_n, vld_n, vld_at, mute_s);
        check("clear_busy_cycles", busy_n, 512);
        check("clear_mute_valid_count", vld_n, 1);
        check("clear_mute_valid_edge", vld_at, 20);
        check("clear_mute_sample", mute_s, 0);

        bad = 0; latbad = 0;
        for (int i = 0; i < 512; i++) begin
            serve(1'b0, s, lat);
            if (s != 0) bad++;
            if (lat != 4) latbad++;
        end
        check("readback_nonzero", bad, 0);
        check("readback_latency", latbad, 0);

        // Pluck len 4, damping off: hand-computed table
        pluck(4);
        fill_len(0, n);
        check("fill4_busy_cycles", n, 4);
        m_fill(4);
        for (int i = 0; i < 8; i++) begin
            bus.iDAMP = 4'(tbl[i].damp);
            serve(1'b0, s, lat);
            check($sformatf("len4_out%0d", i + 1), s, tbl[i].exp);
            check($sformatf("len4_lat%0d", i + 1), lat, 4);
        end

        // Pluck coincident with request in IDLE: sample first, then FILL
        bus.iLEN = 10'd4;
        serve(1'b1, s, lat);
        check("coll_sample", s, int'($signed(16'h027D)));
        check("coll_latency", lat, 4);
        fill_len(0, n);
        check("coll_fill_busy_cycles", n, 4);
        m_fill(4);
        serve(1'b0, s, lat);
        m_serve(0, e);
        check("coll_first_after_fill", s, e);

        // Pluck during FILL is ignored
        pluck(4);
        fill_len(2, n);
        check("fillpluck_busy_cycles", n, 4);
        m_fill(4);
        vc = 0;
        repeat (10) begin
            tick();
            if (bus.oBUSY) vc++;
        end
        check("fillpluck_no_refill", vc, 0);

        // Request arriving during RD_B is dropped
        bus.iSAMPLE_REQ = 1'b1; tick();
        bus.iSAMPLE_REQ = 1'b0; tick();
        bus.iSAMPLE_REQ = 1'b1; tick();
        bus.iSAMPLE_REQ = 1'b0;
        vc = 0; s = -99999;
        repeat (12) begin
            tick();
            if (bus.oVALID) begin
                vc++;
                s = int'(bus.oSAMPLE);
            end
        end
        check("rdb_valid_count", vc, 1);
        m_serve(0, e);
        check("rdb_sample", s, e);
        serve(1'b0, s, lat);
        m_serve(0, e);
        check("rdb_next_sample", s, e);
        check("rdb_next_latency", lat, 4);

        // iLEN=0 clamps to 2 and settles to a constant
        pluck(0);
        fill_len(0, n);
        check("len0_busy_cycles", n, 2);
        m_fill(2);
        f0 = line_m[0]; f1 = line_m[1];
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            serve(1'b0, outs[i], lat);
            m_serve(0, e);
            if (outs[i] != e || lat != 4) bad++;
        end
        check("len0_model", bad, 0);
        check("len0_out3", outs[2], avg2(f0, f1));
        check("len0_settled", outs[39], outs[38]);

        // iLEN=1000 clamps to 512
        pluck(1000);
        fill_len(0, n);
        check("len1000_busy_cycles", n, 512);
        m_fill(512);
        f0 = line_m[0]; f1 = line_m[1];
        bad = 0;
        for (int i = 0; i < 513; i++) begin
            serve(1'b0, outs[i], lat);
            m_serve(0, e);
            if (outs[i] != e || lat != 4) bad++;
        end
        check("len1000_model", bad, 0);
        check("len1000_out513", outs[512], avg2(f0, f1));

        // Damping: iDAMP=1, len 8 decays to |x| <= 1 and never grows
        bus.iDAMP = 4'd1;
        pluck(8);
        fill_len(0, n);
        check("damp_busy_cycles", n, 8);
        m_fill(8);
        bad = 0; grow = 0; prev = 0;
        for (int p = 0; p < 41; p++) begin
            peak = 0;
            for (int j = 0; j < 8; j++) begin
                serve(1'b0, s, lat);
                m_serve(1, e);
                if (s != e) bad++;
                if ((s < 0 ? -s : s) > peak) peak = (s < 0 ? -s : s);
            end
            if (p > 0 && peak > prev) grow++;
            prev = peak;
        end
        check("damp_model", bad, 0);
        check("damp_growth_events", grow, 0);
        check("damp_final_peak_le1", (prev <= 1) ? 1 : 0, 1);
        bus.iDAMP = 4'd0;

        // Reset mid-FILL: no valid, full CLEAR, silent afterwards
        pluck(300);
        for (int i = 0; i < 20; i++) begin
            if (bus.oBUSY) break;
            tick();
        end
        repeat (50) tick();
        check("midfill_busy_before_rst", int'(bus.oBUSY), 1);
        rst = 1'b1;
        vc = 0;
        repeat (3) begin
            tick();
            if (bus.oVALID) vc++;
        end
        lfsr_m = 16'hACE1;
        run_clear(-1, busy_n, vld_n, vld_at, mute_s);
        check("midfill_rst_valids", vc + vld_n, 0);
        check("midfill_clear_cycles", busy_n, 512);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, s, lat);
            if (s != 0 || lat != 4) bad++;
        end
        check("post_rst_silent", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
